gate_ctrl: RTL and testbench

GATE_CTRL -- requirements
Module: gate_ctrl

---
 rtl/gate_ctrl_pkg.sv | 14 +
 rtl/gate_ctrl_if.sv | 45 ++++
 rtl/gate_cfg_chk.sv | 15 +
 rtl/gate_ctrl.sv | 167 ++++++++++++++++
 tb/tb_gate_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_ctrl_pkg.sv
// Shared definitions for the gate_ctrl measurement-gate generator:
// FSM state encoding and the default field widths.
package gate_ctrl_pkg;

  localparam int CNT_W_DEF = 25;
  localparam int WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/gate_ctrl_if.sv
// Control/status bundle for gate_ctrl. The master side issues start/stop
// and configuration; the slave side (the gate generator) drives the gate
// and status pulses. Optional macro: GATE_CTRL_WIN_CNT_EN adds win_cnt.
interface gate_ctrl_if #(
  parameter int CNT_W = gate_ctrl_pkg::CNT_W_DEF,
  parameter int WIN_W = gate_ctrl_pkg::WIN_W_DEF
);

  logic             start;
  logic             stop;
  logic             one_shot;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_len;
  logic             gate;
  logic             gate_rise;
  logic             gate_fall;
  logic             busy;
  logic             done;
  logic             cfg_err;

`ifdef GATE_CTRL_WIN_CNT_EN
  logic [WIN_W-1:0] win_cnt;

  modport master (
    output start, stop, one_shot, period, high_len,
    input  gate, gate_rise, gate_fall, busy, done, cfg_err, win_cnt
  );

  modport slave (
    input  start, stop, one_shot, period, high_len,
    output gate, gate_rise, gate_fall, busy, done, cfg_err, win_cnt
  );
`else
  modport master (
    output start, stop, one_shot, period, high_len,
    input  gate, gate_rise, gate_fall, busy, done, cfg_err
  );

  modport slave (
    input  start, stop, one_shot, period, high_len,
    output gate, gate_rise, gate_fall, busy, done, cfg_err
  );
`endif

endinterface

// File: rtl/gate_cfg_chk.sv
// Combinational legality check of a gate configuration: a period needs at
// least one high and one low cycle, so 1 <= high_len < period (period >= 2).
module gate_cfg_chk
  import gate_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_len,
  output logic             legal
);

  assign legal = (period >= CNT_W'(2)) && (high_len != '0) && (high_len < period);

endmodule

// File: rtl/gate_ctrl.sv
// Measurement-gate generator. A legal start launches periods of
// high_len gate-high cycles followed by period-high_len low cycles,
// either once (one_shot) or continuously until stop, re-latching the
// configuration at every period boundary. A single phase counter runs
// 0..period-1 across both phases, so it can never wrap.
// Optional macro: GATE_CTRL_WIN_CNT_EN adds the completed-period counter
// win_cnt on the interface.
module gate_ctrl
  import gate_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic        clock,
  input  logic        rst_n,
  gate_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, high_q;
  logic             one_shot_q;
  logic             pend_q, pend_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             latch_cfg;
  logic             latch_mode;
  logic             win_clr;
  logic             win_inc;
  logic             cfg_ok;

  gate_cfg_chk #(.CNT_W(CNT_W)) u_cfg_chk (
    .period   (bus.period),
    .high_len (bus.high_len),
    .legal    (cfg_ok)
  );

  // Next-state, phase counter, pending stop and one-cycle status pulses.
  always_comb begin
    // NOTE: every signal gets a default first so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    latch_cfg  = 1'b0;
    latch_mode = 1'b0;
    win_clr    = 1'b0;
    win_inc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (bus.start) begin
          if (cfg_ok) begin
            state_d    = HIGH;
            cnt_d      = '0;
            rise_d     = 1'b1;
            latch_cfg  = 1'b1;
            latch_mode = 1'b1;
            win_clr    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      HIGH: begin
        if (bus.stop) pend_d = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == high_q - CNT_W'(1)) begin
          state_d = LOW;
          fall_d  = 1'b1;
        end
      end

      LOW: begin
        if (bus.stop) pend_d = 1'b1;
        if (cnt_q == period_q - CNT_W'(1)) begin
          // Period boundary: finish, restart with fresh config, or reject it.
          win_inc = 1'b1;
          cnt_d   = '0;
          if (one_shot_q || pend_q || bus.stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
            pend_d  = 1'b0;
          end else if (cfg_ok) begin
            state_d   = HIGH;
            rise_d    = 1'b1;
            latch_cfg = 1'b1;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
            pend_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counter, configuration latches and registered pulses.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all registers, configuration latches included, are reset so nothing X reaches the outputs.
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      high_q     <= '0;
      one_shot_q <= 1'b0;
      pend_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (latch_cfg) begin
        period_q <= bus.period;
        high_q   <= bus.high_len;
      end
      if (latch_mode) one_shot_q <= bus.one_shot;
    end
  end

  assign bus.gate      = (state_q == HIGH);
  assign bus.busy      = (state_q != IDLE);
  assign bus.gate_rise = rise_q;
  assign bus.gate_fall = fall_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = err_q;

`ifdef GATE_CTRL_WIN_CNT_EN
  logic [WIN_W-1:0] win_q;

  // Completed-period counter: cleared by a legal start, wraps naturally.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (win_clr) begin
      win_q <= '0;
    end else if (win_inc) begin
      win_q <= win_q + WIN_W'(1);
    end
  end

  assign bus.win_cnt = win_q;
`else
  logic unused_win;
  assign unused_win = win_clr ^ win_inc;
`endif

endmodule

// File: tb/tb_gate_ctrl.sv
// Self-checking bench for gate_ctrl: directed scenarios plus a random
// phase, compared every cycle against a period-arithmetic reference model.
module tb_gate_ctrl;

  localparam int CNT_W = 8;
  localparam int WIN_W = 2;
  localparam int HN    = 4096;

  logic clock = 1'b0;
  logic rst_n;

  always #5 clock = ~clock;

  gate_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

  gate_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a run is a sequence of periods; m_s is the first
  // cycle of the current period, m_p/m_h its length and high time.
  int m_c;
  bit m_act;
  int m_s, m_p, m_h;
  bit m_os, m_stop;
  int m_done_at, m_err_at;
  int m_win;

  logic gate_h [HN];
  logic rise_h [HN];
  logic fall_h [HN];
  logic busy_h [HN];
  logic done_h [HN];
  logic err_h  [HN];
  int   win_h  [HN];
  int   done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, m_c, obs, exp);
    end
  endtask

  function automatic bit legal(input int p, input int h);
    return (p >= 2) && (h >= 1) && (h < p);
  endfunction

  task automatic model_reset();
    m_act     = 1'b0;
    m_stop    = 1'b0;
    m_win     = 0;
    m_done_at = -1;
    m_err_at  = -1;
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_edge();
    int p, h;
    p = int'(bus.period);
    h = int'(bus.high_len);
    if (m_act) begin
      if (bus.stop) m_stop = 1'b1;
      if (m_c == m_s + m_p - 1) begin
        m_win++;
        if (m_os || m_stop) begin
          m_act = 1'b0; m_stop = 1'b0; m_done_at = m_c + 1;
        end else if (legal(p, h)) begin
          m_s = m_c + 1; m_p = p; m_h = h;
        end else begin
          m_act = 1'b0; m_stop = 1'b0; m_err_at = m_c + 1;
        end
      end
    end else if (bus.start) begin
      if (legal(p, h)) begin
        m_act = 1'b1; m_s = m_c + 1; m_p = p; m_h = h;
        m_os = bus.one_shot; m_win = 0; m_stop = 1'b0;
      end else begin
        m_err_at = m_c + 1;
      end
    end
    m_c++;
  endtask

  // One clock: update the model, let the edge happen, then compare mid-cycle.
  task automatic cycle();
    model_edge();
    @(posedge clock);
    @(negedge clock);
    if (m_c < HN) begin
      gate_h[m_c] = bus.gate;
      rise_h[m_c] = bus.gate_rise;
      fall_h[m_c] = bus.gate_fall;
      busy_h[m_c] = bus.busy;
      done_h[m_c] = bus.done;
      err_h[m_c]  = bus.cfg_err;
`ifdef GATE_CTRL_WIN_CNT_EN
      win_h[m_c]  = int'(bus.win_cnt);
`else
      win_h[m_c]  = 0;
`endif
    end
    if (bus.done === 1'b1) done_seen++;
    check("gate",      32'(bus.gate),      32'(m_act && (m_c - m_s) < m_h));
    check("gate_rise", 32'(bus.gate_rise), 32'(m_act && m_c == m_s));
    check("gate_fall", 32'(bus.gate_fall), 32'(m_act && m_c == m_s + m_h));
    check("busy",      32'(bus.busy),      32'(m_act));
    check("done",      32'(bus.done),      32'(m_c == m_done_at));
    check("cfg_err",   32'(bus.cfg_err),   32'(m_c == m_err_at));
`ifdef GATE_CTRL_WIN_CNT_EN
    check("win_cnt",   32'(bus.win_cnt),   32'(m_win % (1 << WIN_W)));
`endif
  endtask

  task automatic set_cfg(input int p, input int h, input bit os);
    bus.period   = CNT_W'(p);
    bus.high_len = CNT_W'(h);
    bus.one_shot = os;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gate"}, 32'(bus.gate),      0);
    check({tag, "_rise"}, 32'(bus.gate_rise), 0);
    check({tag, "_fall"}, 32'(bus.gate_fall), 0);
    check({tag, "_busy"}, 32'(bus.busy),      0);
    check({tag, "_done"}, 32'(bus.done),      0);
    check({tag, "_err"},  32'(bus.cfg_err),   0);
  endtask

  initial begin
    int b;
    int ill_p [3];
    int ill_h [3];

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(0, 0, 1'b0);
    m_c       = 0;
    m_s       = 0;
    m_p       = 0;
    m_h       = 0;
    m_os      = 1'b0;
    done_seen = 0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle_outputs("reset");
`ifdef GATE_CTRL_WIN_CNT_EN
    check("reset_win", 32'(bus.win_cnt), 0);
`endif
    rst_n = 1'b1;

    // Continuous 10/5 started on the first edge after reset; stop in period 2 HIGH.
    b = m_c;
    set_cfg(10, 5, 1'b0);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (11) cycle();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    repeat (12) cycle();
    check("c10_gate1",  32'(gate_h[b+1]),  1);
    check("c10_gate5",  32'(gate_h[b+5]),  1);
    check("c10_gate6",  32'(gate_h[b+6]),  0);
    check("c10_gate10", 32'(gate_h[b+10]), 0);
    check("c10_gate11", 32'(gate_h[b+11]), 1);
    check("c10_rise1",  32'(rise_h[b+1]),  1);
    check("c10_rise11", 32'(rise_h[b+11]), 1);
    check("c10_fall6",  32'(fall_h[b+6]),  1);
    check("c10_busy20", 32'(busy_h[b+20]), 1);
    check("c10_done21", 32'(done_h[b+21]), 1);
    check("c10_busy21", 32'(busy_h[b+21]), 0);
    check("c10_done_n", 32'(done_seen),    1);

    // One-shot 4/1.
    b = m_c;
    set_cfg(4, 1, 1'b1);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (7) cycle();
    check("os_gate1", 32'(gate_h[b+1]), 1);
    check("os_gate2", 32'(gate_h[b+2]), 0);
    check("os_busy4", 32'(busy_h[b+4]), 1);
    check("os_done5", 32'(done_h[b+5]), 1);
    check("os_busy5", 32'(busy_h[b+5]), 0);

    // Illegal configurations.
    ill_p = '{1, 5, 6};
    ill_h = '{0, 0, 6};
    for (int i = 0; i < 3; i++) begin
      b = m_c;
      set_cfg(ill_p[i], ill_h[i], 1'b0);
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      cycle();
      check("ill_err",  32'(err_h[b+1]),  1);
      check("ill_gate", 32'(gate_h[b+1]), 0);
      check("ill_busy", 32'(busy_h[b+1]), 0);
      check("ill_err2", 32'(err_h[b+2]),  0);
    end

    // start and stop together in IDLE: run starts, stop is not remembered.
    b = m_c;
    set_cfg(3, 1, 1'b0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (6) cycle();
    check("ss_busy4", 32'(busy_h[b+4]), 1);
    check("ss_rise4", 32'(rise_h[b+4]), 1);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    repeat (5) cycle();

    // Config change while busy applies at the boundary; illegal re-latch ends in IDLE.
    b = m_c;
    set_cfg(6, 3, 1'b0);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();
    set_cfg(8, 2, 1'b0);
    repeat (8) cycle();
    set_cfg(1, 0, 1'b0);
    repeat (7) cycle();
    check("chg_gate3", 32'(gate_h[b+3]),  1);
    check("chg_gate4", 32'(gate_h[b+4]),  0);
    check("chg_gate8", 32'(gate_h[b+8]),  1);
    check("chg_gate9", 32'(gate_h[b+9]),  0);
    check("chg_err15", 32'(err_h[b+15]),  1);
    check("chg_busy15", 32'(busy_h[b+15]), 0);
    check("chg_done15", 32'(done_h[b+15]), 0);

    // Reset in the 3rd HIGH cycle, then a normal run two cycles later.
    set_cfg(10, 5, 1'b0);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("arst");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    check_idle_outputs("arst_hold");
    rst_n = 1'b1;
    m_c   = m_c + 1;
    repeat (2) cycle();
    b = m_c;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (12) cycle();
    check("post_rst_gate1", 32'(gate_h[b+1]), 1);
    check("post_rst_rise1", 32'(rise_h[b+1]), 1);
    check("post_rst_fall6", 32'(fall_h[b+6]), 1);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    repeat (12) cycle();

`ifdef GATE_CTRL_WIN_CNT_EN
    // Completed-period counter wraps modulo 4 over five 3/1 periods.
    b = m_c;
    set_cfg(3, 1, 1'b0);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (16) cycle();
    check("win_p1", 32'(win_h[b+4]),  1);
    check("win_p2", 32'(win_h[b+7]),  2);
    check("win_p3", 32'(win_h[b+10]), 3);
    check("win_p4", 32'(win_h[b+13]), 0);
    check("win_p5", 32'(win_h[b+16]), 1);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    repeat (4) cycle();
`endif

    // Random traffic: sparse start/stop, occasional config changes.
    for (int i = 0; i < 600; i++) begin
      int p, h;
      bus.start = ($urandom_range(0, 9) == 0);
      bus.stop  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 11) == 0) begin
        p = int'($urandom_range(1, 9));
        h = int'($urandom_range(0, p));
        set_cfg(p, h, 1'($urandom_range(0, 1)));
      end
      cycle();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    cycle();
    bus.stop  = 1'b0;
    repeat (12) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
